// File: rtl/mailbox_exchanger.sv
// Dual-port ARM/NIOS mailbox: a shared word array split into two owner regions, with
// per-word pending flags and a level interrupt toward the consuming side.
module mailbox_exchanger #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SPLIT  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [ADDR_W-1:0]           arm_addr_i,
  input  logic [DATA_W-1:0]           arm_wdata_i,
  input  logic                        arm_wr_i,
  input  logic                        arm_rd_i,
  output logic [DATA_W-1:0]           arm_rdata_o,
  output logic                        arm_rvalid_o,
  output logic                        arm_wr_err_o,
  output logic [(2**ADDR_W)-SPLIT-1:0] arm_pending_o,
  output logic                        arm_irq_o,
  input  logic [ADDR_W-1:0]           nios_addr_i,
  input  logic [DATA_W-1:0]           nios_wdata_i,
  input  logic                        nios_wr_i,
  input  logic                        nios_rd_i,
  output logic [DATA_W-1:0]           nios_rdata_o,
  output logic                        nios_rvalid_o,
  output logic                        nios_wr_err_o,
  output logic [SPLIT-1:0]            nios_pending_o,
  output logic                        nios_irq_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NIOS_WORDS = DEPTH - SPLIT;
  localparam logic [ADDR_W-1:0] SplitAddr = ADDR_W'(SPLIT);

  if (SPLIT < 1 || SPLIT >= DEPTH) begin : g_bad_split
    $error("mailbox_exchanger: SPLIT must lie in 1..DEPTH-1");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic arm_in_arm, nios_in_arm;
  logic arm_own_wr, nios_own_wr;

  logic [DATA_W-1:0]     arm_rdata_q, nios_rdata_q;
  logic                  arm_rvalid_q, nios_rvalid_q;
  logic                  arm_wr_err_q, nios_wr_err_q;
  logic [NIOS_WORDS-1:0] arm_pending_q, arm_pending_d;
  logic [SPLIT-1:0]      nios_pending_q, nios_pending_d;

  assign arm_in_arm  = arm_addr_i < SplitAddr;
  assign nios_in_arm = nios_addr_i < SplitAddr;
  assign arm_own_wr  = arm_wr_i && arm_in_arm;
  assign nios_own_wr = nios_wr_i && !nios_in_arm;

  // Ownership keeps the two write addresses disjoint, so both ports share one array.
  always_ff @(posedge clk_i) begin
    if (arm_own_wr) begin
      mem[arm_addr_i] <= arm_wdata_i;
    end
    if (nios_own_wr) begin
      mem[nios_addr_i] <= nios_wdata_i;
    end
  end

  // Set beats clear so a post racing a consumer read is never lost.
  always_comb begin
    nios_pending_d = nios_pending_q;
    for (int unsigned i = 0; i < SPLIT; i++) begin
      if (arm_own_wr && arm_addr_i == ADDR_W'(i)) begin
        nios_pending_d[i] = 1'b1;
      end else if (nios_rd_i && nios_addr_i == ADDR_W'(i)) begin
        nios_pending_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    arm_pending_d = arm_pending_q;
    for (int unsigned i = 0; i < NIOS_WORDS; i++) begin
      if (nios_own_wr && nios_addr_i == ADDR_W'(SPLIT + i)) begin
        arm_pending_d[i] = 1'b1;
      end else if (arm_rd_i && arm_addr_i == ADDR_W'(SPLIT + i)) begin
        arm_pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      arm_rdata_q    <= '0;
      nios_rdata_q   <= '0;
      arm_rvalid_q   <= 1'b0;
      nios_rvalid_q  <= 1'b0;
      arm_wr_err_q   <= 1'b0;
      nios_wr_err_q  <= 1'b0;
      arm_pending_q  <= '0;
      nios_pending_q <= '0;
    end else begin
      if (arm_rd_i) begin
        arm_rdata_q <= mem[arm_addr_i];
      end
      if (nios_rd_i) begin
        nios_rdata_q <= mem[nios_addr_i];
      end
      arm_rvalid_q   <= arm_rd_i;
      nios_rvalid_q  <= nios_rd_i;
      arm_wr_err_q   <= arm_wr_i && !arm_in_arm;
      nios_wr_err_q  <= nios_wr_i && nios_in_arm;
      arm_pending_q  <= arm_pending_d;
      nios_pending_q <= nios_pending_d;
    end
  end

  assign arm_rdata_o    = arm_rdata_q;
  assign nios_rdata_o   = nios_rdata_q;
  assign arm_rvalid_o   = arm_rvalid_q;
  assign nios_rvalid_o  = nios_rvalid_q;
  assign arm_wr_err_o   = arm_wr_err_q;
  assign nios_wr_err_o  = nios_wr_err_q;
  assign arm_pending_o  = arm_pending_q;
  assign nios_pending_o = nios_pending_q;
  assign arm_irq_o      = |arm_pending_q;
  assign nios_irq_o     = |nios_pending_q;

endmodule
